mult_sched_2ch: RTL

MULT_SCHED_2CH -- requirements
Module: mult_sched_2ch

---
 rtl/mult_sched_2ch.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mult_sched_2ch.sv
// Two-channel round-robin scheduler for one shared 4x4 multiplier.
// Define MULT_SCHED_ZERO_BYPASS_EN to answer zero-operand requests without the multiplier.
module mult_sched_2ch #(
  parameter int unsigned MULT_LAT = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [3:0] a0_i,
  input  logic [3:0] b0_i,
  input  logic [3:0] a1_i,
  input  logic [3:0] b1_i,
  output logic [1:0] gnt_o,
  output logic [1:0] done_o,
  output logic [7:0] y0_o,
  output logic [7:0] y1_o,
  output logic       busy_o,
  output logic       mult_en_o,
  output logic [3:0] mult_a_o,
  output logic [3:0] mult_b_o,
  input  logic [7:0] mult_y_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ptr_q;
  logic       win_q;
  logic       win;
  logic [3:0] win_a, win_b;
  logic       take, zero, fire, byp, fin;

  // ptr_q holds the last granted channel; on a tie the other one wins
  always_comb begin
    win   = req_i[1] & (~req_i[0] | ~ptr_q);
    win_a = win ? a1_i : a0_i;
    win_b = win ? b1_i : b0_i;
    take  = (state_q == IDLE) && (req_i != 2'b00);
`ifdef MULT_SCHED_ZERO_BYPASS_EN
    zero  = (win_a == 4'd0) || (win_b == 4'd0);
`else
    zero  = 1'b0;
`endif
    fire  = take & ~zero;
    byp   = take & zero;
    fin   = (state_q == WAIT) && (cnt_q <= 4'd1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mult_en_o = 1'b0;
    busy_o    = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (fire) state_d = ISSUE;
      end
      ISSUE: begin
        mult_en_o = 1'b1;
        cnt_d     = 4'(MULT_LAT);
        state_d   = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (fin) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr_q    <= 1'b1;
      win_q    <= 1'b0;
      gnt_o    <= 2'b00;
      done_o   <= 2'b00;
      y0_o     <= 8'd0;
      y1_o     <= 8'd0;
      mult_a_o <= 4'd0;
      mult_b_o <= 4'd0;
    end else begin
      gnt_o  <= 2'b00;
      done_o <= 2'b00;
      if (take) begin
        ptr_q <= win;
        win_q <= win;
        gnt_o <= {win, ~win};
      end
      if (fire) begin
        mult_a_o <= win_a;
        mult_b_o <= win_b;
      end
      // bypass: result is known to be zero, report it with the grant
      if (byp) begin
        done_o <= {win, ~win};
        if (win) y1_o <= 8'd0;
        else     y0_o <= 8'd0;
      end
      if (fin) begin
        done_o <= {win_q, ~win_q};
        if (win_q) y1_o <= mult_y_i;
        else       y0_o <= mult_y_i;
      end
    end
  end

endmodule
